// File: rtl/uncached_dbus_bridge_pkg.sv
// Shared bus types for the uncached data path, plus the bridge's own FSM state.
// The dbus side is the MMU-translated request; the cbus side goes to the memory arbiter.
package uncached_dbus_bridge_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;
  typedef logic [2:0]  msize_t;
  typedef logic [3:0]  mlen_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;

  // cbus length field is beats minus one
  localparam mlen_t MLEN1 = 4'd0;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic    valid;
    logic    is_write;
    msize_t  size;
    addr_t   addr;
    strobe_t strobe;
    word_t   data;
    mlen_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    UCBR_IDLE  = 2'd0,
    UCBR_WRITE = 2'd1,
    UCBR_READ  = 2'd2,
    UCBR_RESP  = 2'd3
  } ucbr_state_t;

endpackage

// File: rtl/uncached_dbus_bridge.sv
// Uncached data-bus responder: turns one accepted dbus request into a single-beat
// cbus transaction, with an optional posted (early data_ok) write.
module uncached_dbus_bridge
  import uncached_dbus_bridge_pkg::*;
#(
  parameter bit POSTED_WRITE = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  input  logic       nocache,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       busy
);

  ucbr_state_t state_reg;
  ucbr_state_t state_next;

  addr_t   addr_reg;
  msize_t  size_reg;
  strobe_t strobe_reg;
  word_t   data_reg;
  word_t   rdata_reg;
  logic    data_ok_reg;

  logic accept;
  logic is_store;
  logic bus_done;

  assign accept   = (state_reg == UCBR_IDLE) & dreq.valid & nocache;
  assign is_store = |dreq.strobe;
  assign bus_done = cresp.ready & cresp.last;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      UCBR_IDLE:  if (accept) state_next = is_store ? UCBR_WRITE : UCBR_READ;
      UCBR_WRITE: if (bus_done) state_next = UCBR_IDLE;
      UCBR_READ:  if (bus_done) state_next = UCBR_RESP;
      UCBR_RESP:  state_next = UCBR_IDLE;
      default:    state_next = UCBR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= UCBR_IDLE;
      addr_reg    <= '0;
      size_reg    <= '0;
      strobe_reg  <= '0;
      data_reg    <= '0;
      rdata_reg   <= '0;
      data_ok_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= dreq.addr;
        size_reg   <= dreq.size;
        strobe_reg <= dreq.strobe;
        data_reg   <= dreq.data;
      end
      if ((state_reg == UCBR_READ) && bus_done) begin
        rdata_reg <= cresp.data;
      end
      // Posted stores acknowledge on acceptance; otherwise wait for the bus beat.
      data_ok_reg <= POSTED_WRITE ? (accept & is_store)
                                  : ((state_reg == UCBR_WRITE) & bus_done);
    end
  end

  always_comb begin
    creq          = '0;
    creq.valid    = (state_reg == UCBR_WRITE) | (state_reg == UCBR_READ);
    creq.is_write = (state_reg == UCBR_WRITE);
    creq.size     = size_reg;
    creq.addr     = addr_reg;
    creq.strobe   = (state_reg == UCBR_WRITE) ? strobe_reg : '0;
    creq.data     = data_reg;
    creq.len      = MLEN1;
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept;
    dresp.data_ok = data_ok_reg | (state_reg == UCBR_RESP);
    dresp.data    = rdata_reg;
  end

  assign busy = (state_reg != UCBR_IDLE);

endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// Bench for uncached_dbus_bridge: lane 0 is a posted-write instance, lane 1 non-posted.
// A transaction-level model predicts every output each cycle; directed cases pin exact latencies.
module tb_uncached_dbus_bridge;
  import uncached_dbus_bridge_pkg::*;

  logic       clk;
  logic       resetn;
  dbus_req_t  dreq    [2];
  logic       nocache [2];
  dbus_resp_t dresp   [2];
  cbus_req_t  creq    [2];
  cbus_resp_t cresp   [2];
  logic       busy    [2];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  int          wait_cfg  [2];
  logic        data_rand [2];
  logic [31:0] data_cfg  [2];

  int          last_cyc    [2];
  int          fv_cyc      [2];
  logic [31:0] fv_addr     [2];
  logic [31:0] fv_data     [2];
  logic [3:0]  fv_strobe   [2];
  logic        fv_is_write [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    uncached_dbus_bridge #(.POSTED_WRITE(gi == 0)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .dreq   (dreq[gi]),
      .nocache(nocache[gi]),
      .dresp  (dresp[gi]),
      .creq   (creq[gi]),
      .cresp  (cresp[gi]),
      .busy   (busy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder: ready&last after the configured number of wait cycles.
  initial begin : responder
    int cnt [2];
    int target [2];
    for (int l = 0; l < 2; l++) begin
      cnt[l] = 0;
      target[l] = 0;
      cresp[l] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
        cresp[l].data = $urandom;
        cresp[l].ready = 1'b0;
        cresp[l].last = 1'b0;
        if (resetn && creq[l].valid) begin
          if (cnt[l] == 0)
            target[l] = (wait_cfg[l] >= 0) ? wait_cfg[l] : int'($urandom_range(0, 5));
          if (cnt[l] == target[l]) begin
            cresp[l].ready = 1'b1;
            cresp[l].last = 1'b1;
            if (!data_rand[l]) cresp[l].data = data_cfg[l];
          end
          cnt[l]++;
        end else begin
          cnt[l] = 0;
        end
      end
    end
  end

  // Transaction-level model: one outstanding request per lane, data_ok scheduled by cycle number.
  initial begin : model
    logic        m_busy  [2];
    logic        m_store [2];
    logic        m_done  [2];
    dbus_req_t   m_buf   [2];
    logic [31:0] m_rdata [2];
    int          dok_due [2];
    logic        pv      [2];
    logic        posted, exp_aok, exp_cv, exp_dok;
    string       ln;
    for (int l = 0; l < 2; l++) begin
      m_busy[l] = 1'b0; m_store[l] = 1'b0; m_done[l] = 1'b0;
      m_buf[l] = '0; m_rdata[l] = '0; dok_due[l] = -1; pv[l] = 1'b0;
      last_cyc[l] = -1; fv_cyc[l] = -1; fv_addr[l] = '0; fv_data[l] = '0;
      fv_strobe[l] = '0; fv_is_write[l] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        posted = (l == 0);
        ln = $sformatf("L%0d", l);
        if (!resetn) begin
          chk({ln, " rst creq"}, creq[l], '0);
          chk({ln, " rst dresp"}, dresp[l], '0);
          chk({ln, " rst busy"}, busy[l], 0);
          m_busy[l] = 1'b0; m_done[l] = 1'b0; dok_due[l] = -1; pv[l] = 1'b0;
          continue;
        end
        exp_aok = !m_busy[l] && dreq[l].valid && nocache[l];
        exp_cv  = m_busy[l] && !m_done[l];
        exp_dok = (dok_due[l] == cyc);
        chk({ln, " addr_ok"}, dresp[l].addr_ok, exp_aok);
        chk({ln, " busy"}, busy[l], m_busy[l]);
        chk({ln, " creq.valid"}, creq[l].valid, exp_cv);
        chk({ln, " data_ok"}, dresp[l].data_ok, exp_dok);
        if (exp_cv) begin
          chk({ln, " creq.is_write"}, creq[l].is_write, m_store[l]);
          chk({ln, " creq.addr"}, creq[l].addr, m_buf[l].addr);
          chk({ln, " creq.size"}, creq[l].size, m_buf[l].size);
          chk({ln, " creq.strobe"}, creq[l].strobe, m_store[l] ? m_buf[l].strobe : 4'h0);
          chk({ln, " creq.len"}, creq[l].len, MLEN1);
          if (m_store[l]) chk({ln, " creq.data"}, creq[l].data, m_buf[l].data);
        end
        if (exp_dok && !m_store[l]) chk({ln, " load data"}, dresp[l].data, m_rdata[l]);
        if (creq[l].valid && !pv[l]) begin
          fv_cyc[l] = cyc; fv_addr[l] = creq[l].addr; fv_data[l] = creq[l].data;
          fv_strobe[l] = creq[l].strobe; fv_is_write[l] = creq[l].is_write;
        end
        pv[l] = creq[l].valid;
        if (creq[l].valid && cresp[l].ready && cresp[l].last) last_cyc[l] = cyc;
        if (exp_aok) begin
          m_busy[l] = 1'b1; m_done[l] = 1'b0; m_buf[l] = dreq[l];
          m_store[l] = (dreq[l].strobe != 4'h0);
          if (m_store[l] && posted) dok_due[l] = cyc + 1;
        end else if (exp_cv && cresp[l].ready && cresp[l].last) begin
          if (m_store[l]) begin
            m_busy[l] = 1'b0;
            if (!posted) dok_due[l] = cyc + 1;
          end else begin
            m_rdata[l] = cresp[l].data; m_done[l] = 1'b1; dok_due[l] = cyc + 1;
          end
        end else if (m_busy[l] && m_done[l]) begin
          m_busy[l] = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int l, input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] sb, output int acc);
    dreq[l].valid = 1'b1; dreq[l].addr = a; dreq[l].data = d;
    dreq[l].strobe = st ? sb : 4'h0; dreq[l].size = MSIZE4; nocache[l] = 1'b1;
    acc = -1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (dresp[l].addr_ok) begin acc = cyc; break; end
      @(posedge clk);
      #1;
    end
    chk($sformatf("L%0d accept within bound", l), (acc >= 0), 1);
    @(posedge clk);
    #1;
    dreq[l] = '0;
  endtask

  task automatic wait_dok(input int l, output int c, output logic [31:0] d);
    c = -1; d = '0;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (dresp[l].data_ok) begin c = cyc; d = dresp[l].data; break; end
      @(posedge clk);
      #1;
    end
    chk($sformatf("L%0d data_ok within bound", l), (c >= 0), 1);
  endtask

  task automatic wait_idle(input int l, output int c);
    c = -1;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (!busy[l]) begin c = cyc; break; end
      @(posedge clk);
      #1;
    end
    chk($sformatf("L%0d idle within bound", l), (c >= 0), 1);
  endtask

  initial begin : main
    int acc, acc2, dc, ic;
    logic [31:0] dd;
    logic st;
    resetn = 1'b1;
    for (int l = 0; l < 2; l++) begin
      dreq[l] = '0; nocache[l] = 1'b0; wait_cfg[l] = 0; data_rand[l] = 1'b1; data_cfg[l] = '0;
    end
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d post-reset creq", l), creq[l], '0);
      chk($sformatf("L%0d post-reset dresp", l), dresp[l], '0);
      chk($sformatf("L%0d post-reset busy", l), busy[l], 0);
    end
    @(posedge clk);
    #1;

    // Load with 3 wait cycles
    wait_cfg[0] = 3; data_rand[0] = 1'b0; data_cfg[0] = 32'hDEAD_BEEF;
    issue(0, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, acc);
    wait_dok(0, dc, dd);
    chk("T1 load latency", dc - acc, 5);
    chk("T1 load data", dd, 32'hDEAD_BEEF);
    chk("T1 last to data_ok", dc - last_cyc[0], 1);
    chk("T1 creq addr", fv_addr[0], 32'hBFC0_0000);
    chk("T1 creq is_write", fv_is_write[0], 0);
    chk("T1 first valid", fv_cyc[0] - acc, 1);

    // Posted store, bus stalled 10 cycles
    wait_cfg[0] = 10;
    issue(0, 1'b1, 32'hA000_0040, 32'h1234_5678, 4'hF, acc);
    wait_dok(0, dc, dd);
    chk("T2 posted data_ok", dc - acc, 1);
    wait_idle(0, ic);
    chk("T2 last cycle", last_cyc[0] - acc, 11);
    chk("T2 idle cycle", ic - acc, 12);
    chk("T2 creq strobe", fv_strobe[0], 4'hF);
    chk("T2 creq data", fv_data[0], 32'h1234_5678);

    // Store immediately followed by a load
    wait_cfg[0] = 2; data_cfg[0] = 32'hCAFE_F00D;
    issue(0, 1'b1, 32'hA000_0080, 32'h5555_AAAA, 4'h3, acc);
    issue(0, 1'b0, 32'hA000_0084, 32'h0, 4'h0, acc2);
    wait_dok(0, dc, dd);
    chk("T3 load held off", acc2 - acc, 4);
    chk("T3 load creq start", fv_cyc[0] - acc2, 1);
    chk("T3 load latency", dc - acc2, 4);
    chk("T3 load data", dd, 32'hCAFE_F00D);

    // Non-posted store with 4 wait cycles
    wait_cfg[1] = 4;
    issue(1, 1'b1, 32'hA000_0100, 32'h0F0F_0F0F, 4'hC, acc);
    wait_dok(1, dc, dd);
    chk("T4 last to data_ok", dc - last_cyc[1], 1);
    chk("T4 store latency", dc - acc, 6);

    // Cached request must be ignored
    dreq[0].valid = 1'b1; dreq[0].addr = 32'h8000_0000; dreq[0].strobe = 4'hF; nocache[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("T5 cached addr_ok", dresp[0].addr_ok, 0);
      chk("T5 cached creq.valid", creq[0].valid, 0);
      chk("T5 cached busy", busy[0], 0);
      @(posedge clk);
      #1;
    end
    dreq[0] = '0;

    // Asynchronous reset during a read wait
    wait_cfg[0] = 8;
    issue(0, 1'b0, 32'hBFC0_0010, 32'h0, 4'h0, acc);
    @(posedge clk);
    #2;
    chk("T6 read pending", creq[0].valid, 1);
    resetn = 1'b0;
    #1;
    chk("T6 async creq", creq[0], '0);
    chk("T6 async busy", busy[0], 0);
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    wait_cfg[0] = 1; data_cfg[0] = 32'h0BAD_F00D;
    issue(0, 1'b0, 32'hBFC0_0020, 32'h0, 4'h0, acc);
    wait_dok(0, dc, dd);
    chk("T6 reload latency", dc - acc, 3);
    chk("T6 reload data", dd, 32'h0BAD_F00D);

    // Randomized traffic on both lanes; the model checks every cycle
    for (int l = 0; l < 2; l++) begin wait_cfg[l] = -1; data_rand[l] = 1'b1; end
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
        st = ($urandom_range(0, 1) == 1);
        dreq[l].valid = ($urandom_range(0, 2) != 0);
        nocache[l] = ($urandom_range(0, 4) != 0);
        dreq[l].addr = $urandom;
        dreq[l].data = $urandom;
        dreq[l].size = 3'($urandom_range(0, 2));
        dreq[l].strobe = st ? 4'($urandom_range(1, 15)) : 4'h0;
      end
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) dreq[l] = '0;
    repeat (20) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
